// File: rtl/tpu_pkg.sv
// Shared sizing, FSM state and tile-command types for the TPU systolic-array control blocks.
package tpu_pkg;

  localparam int unsigned ARRAY_DIM = 4;
  localparam int unsigned DIM_W     = 4;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } sched_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] a_base;
    logic [IDX_W-1:0] b_base;
    logic [IDX_W-1:0] o_base;
    logic [DIM_W-1:0] k_len;
    logic [CNT_W-1:0] rows;
    logic [CNT_W-1:0] cols;
  } tile_cmd_t;

  // Valid rows/cols of a tile given the remaining extent from its origin.
  function automatic logic [CNT_W-1:0] clip_tile(input logic [DIM_W-1:0] remain);
    return (remain >= DIM_W'(ARRAY_DIM)) ? CNT_W'(ARRAY_DIM) : CNT_W'(remain);
  endfunction

  // ceil(len / ARRAY_DIM) without a divider.
  function automatic logic [DIM_W-2:0] tile_count(input logic [DIM_W-1:0] len);
    logic [DIM_W:0] sum;
    sum = {1'b0, len} + (DIM_W + 1)'(ARRAY_DIM - 1);
    return sum[DIM_W:2];
  endfunction

endpackage

// File: rtl/tpu_tile_iter.sv
// Output-tile walker: (r,c) position with last-tile detection and the registered command
// fields for the current tile, updated incrementally so no multipliers are needed.
module tpu_tile_iter
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  input  logic [DIM_W-1:0] k,
  output tile_cmd_t        cmd,
  output logic             last_c
);

  localparam int unsigned POS_W  = DIM_W - 2;
  localparam int unsigned TCNT_W = DIM_W - 1;

  logic [DIM_W-1:0]  m_q, n_q;
  logic [TCNT_W-1:0] mt_q, nt_q;
  logic [POS_W-1:0]  r_q, c_q, r_d, c_d;
  logic [IDX_W-1:0]  col_base_q, col_base_d;
  tile_cmd_t         cmd_q, cmd_d;
  logic              last_row_c, last_col_c;

  assign last_row_c = (TCNT_W'(r_q) == mt_q - TCNT_W'(1));
  assign last_col_c = (TCNT_W'(c_q) == nt_q - TCNT_W'(1));
  assign last_c     = last_row_c && last_col_c;
  assign cmd        = cmd_q;

  // r is the inner loop; wrapping it steps c and rebases A/B/O for the next column tile.
  always_comb begin
    r_d        = r_q;
    c_d        = c_q;
    col_base_d = col_base_q;
    cmd_d      = cmd_q;
    if (load) begin
      r_d          = '0;
      c_d          = '0;
      col_base_d   = '0;
      cmd_d.a_base = '0;
      cmd_d.b_base = '0;
      cmd_d.o_base = '0;
      cmd_d.k_len  = k;
      cmd_d.rows   = clip_tile(m);
      cmd_d.cols   = clip_tile(n);
    end else if (advance) begin
      if (last_row_c) begin
        r_d          = '0;
        c_d          = c_q + POS_W'(1);
        col_base_d   = col_base_q + IDX_W'(m_q);
        cmd_d.a_base = '0;
        cmd_d.b_base = cmd_q.b_base + IDX_W'(cmd_q.k_len);
        cmd_d.o_base = col_base_d;
        cmd_d.rows   = clip_tile(m_q);
        cmd_d.cols   = clip_tile(n_q - {c_d, 2'b00});
      end else begin
        r_d          = r_q + POS_W'(1);
        cmd_d.a_base = cmd_q.a_base + IDX_W'(cmd_q.k_len);
        cmd_d.o_base = cmd_q.o_base + IDX_W'(ARRAY_DIM);
        cmd_d.rows   = clip_tile(m_q - {r_d, 2'b00});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q        <= '0;
      n_q        <= '0;
      mt_q       <= '0;
      nt_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      col_base_q <= '0;
      cmd_q      <= '0;
    end else begin
      if (load) begin
        m_q  <= m;
        n_q  <= n;
        mt_q <= tile_count(m);
        nt_q <= tile_count(n);
      end
      r_q        <= r_d;
      c_q        <= c_d;
      col_base_q <= col_base_d;
      cmd_q      <= cmd_d;
    end
  end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Sequences an A(m x k) * B(k x n) multiply as output-tile commands to the PE array datapath.
// Define TPU_SCHED_PREFETCH_EN to allow two tiles in flight (next load overlaps prior drain).
module tpu_tile_scheduler
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  input  logic [DIM_W-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [IDX_W-1:0] cmd_a_base,
  output logic [IDX_W-1:0] cmd_b_base,
  output logic [IDX_W-1:0] cmd_o_base,
  output logic [DIM_W-1:0] cmd_k_len,
  output logic [CNT_W-1:0] cmd_rows,
  output logic [CNT_W-1:0] cmd_cols,
  input  logic             tile_done
);

`ifdef TPU_SCHED_PREFETCH_EN
  localparam int unsigned MAX_OUT = 2;
`else
  localparam int unsigned MAX_OUT = 1;
`endif
  localparam int unsigned OUT_W = 2;

  sched_state_t     state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             all_issued_q, all_issued_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             hs_c, td_c, zero_c, load_c, last_c;
  tile_cmd_t        cmd;

  assign hs_c   = cmd_valid_q && cmd_ready;
  assign td_c   = tile_done && (out_q != '0);
  assign zero_c = (m == '0) || (n == '0) || (k == '0);
  assign load_c = (state_q == ST_IDLE) && start;

  tpu_tile_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .advance (hs_c),
    .m       (m),
    .n       (n),
    .k       (k),
    .cmd     (cmd),
    .last_c  (last_c)
  );

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    all_issued_d = all_issued_q;
    if (hs_c && !td_c) begin
      out_d = out_q + OUT_W'(1);
    end else if (!hs_c && td_c) begin
      out_d = out_q - OUT_W'(1);
    end
    if (hs_c && last_c) begin
      all_issued_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          out_d        = '0;
          all_issued_d = 1'b0;
          state_d      = zero_c ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs_c && (last_c || (out_d >= OUT_W'(MAX_OUT)))) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (out_d == '0) begin
          state_d = all_issued_q ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        if (done_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A zero-dimension request reaches FINISH straight from IDLE, so done waits one extra cycle.
    busy_d      = (state_d != ST_IDLE);
    cmd_valid_d = (state_d == ST_ISSUE);
    done_d      = (state_d == ST_FINISH) && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      all_issued_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      all_issued_q <= all_issued_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_valid_q  <= cmd_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_a_base = cmd.a_base;
  assign cmd_b_base = cmd.b_base;
  assign cmd_o_base = cmd.o_base;
  assign cmd_k_len  = cmd.k_len;
  assign cmd_rows   = cmd.rows;
  assign cmd_cols   = cmd.cols;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler with a command scoreboard filled from a reference tile walk.
module tb_tpu_tile_scheduler;
  import tpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, cmd_ready, tile_done;
  logic [DIM_W-1:0] m, n, k;
  logic             busy, done, cmd_valid;
  logic [IDX_W-1:0] cmd_a_base, cmd_b_base, cmd_o_base;
  logic [DIM_W-1:0] cmd_k_len;
  logic [CNT_W-1:0] cmd_rows, cmd_cols;

  int checks = 0;
  int errors = 0;
  tile_cmd_t exp_q[$];

  always #5 clk = ~clk;

  tpu_tile_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m          (m),
    .n          (n),
    .k          (k),
    .busy       (busy),
    .done       (done),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a_base (cmd_a_base),
    .cmd_b_base (cmd_b_base),
    .cmd_o_base (cmd_o_base),
    .cmd_k_len  (cmd_k_len),
    .cmd_rows   (cmd_rows),
    .cmd_cols   (cmd_cols),
    .tile_done  (tile_done)
  );

  function automatic tile_cmd_t seen();
    tile_cmd_t t;
    t.a_base = cmd_a_base;
    t.b_base = cmd_b_base;
    t.o_base = cmd_o_base;
    t.k_len  = cmd_k_len;
    t.rows   = cmd_rows;
    t.cols   = cmd_cols;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference walk: column tiles outer, row tiles inner.
  task automatic push_tiles(input int mm, input int nn, input int kk);
    tile_cmd_t t;
    for (int c = 0; c < (nn + 3) / 4; c++) begin
      for (int r = 0; r < (mm + 3) / 4; r++) begin
        t.a_base = IDX_W'(r * kk);
        t.b_base = IDX_W'(c * kk);
        t.o_base = IDX_W'(c * mm + 4 * r);
        t.k_len  = DIM_W'(kk);
        t.rows   = CNT_W'((mm - 4 * r) > 4 ? 4 : mm - 4 * r);
        t.cols   = CNT_W'((nn - 4 * c) > 4 ? 4 : nn - 4 * c);
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic kick(input int mm, input int nn, input int kk);
    start = 1'b1;
    m = DIM_W'(mm);
    n = DIM_W'(nn);
    k = DIM_W'(kk);
    tick();
    start = 1'b0;
    m = DIM_W'($urandom);
    n = DIM_W'($urandom);
    k = DIM_W'($urandom);
  endtask

  task automatic accept(input string tag);
    int waited = 0;
    tile_cmd_t want;
    cmd_ready = 1'b1;
    while (!cmd_valid && waited < 40) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, 64'(cmd_valid), 64'(1));
    chk({tag, "_sb"}, 64'(exp_q.size() != 0), 64'(1));
    if (cmd_valid && exp_q.size() != 0) begin
      want = exp_q.pop_front();
      chk({tag, "_cmd"}, 64'(seen()), 64'(want));
    end
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_done();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
  endtask

  // Called in the cycle after the final tile_done.
  task automatic finish_check(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_done"}, 64'(busy), 64'(1));
    tick();
    chk({tag, "_done_clr"}, 64'(done), 64'(0));
    chk({tag, "_busy_clr"}, 64'(busy), 64'(0));
    chk({tag, "_idle"}, 64'(dut.state_q == ST_IDLE), 64'(1));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cmd_ready = 1'b0;
    tile_done = 1'b0;
    m = '0;
    n = '0;
    k = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_cmd", 64'(seen()), 64'(0));
    rst = 1'b0;
    tick();

    // Single full tile
    push_tiles(4, 4, 4);
    kick(4, 4, 4);
    chk("a_busy_t1", 64'(busy), 64'(1));
    chk("a_valid_t1", 64'(cmd_valid), 64'(1));
    accept("a0");
    repeat (3) begin
      chk("a_wait_valid", 64'(cmd_valid), 64'(0));
      tick();
    end
    pulse_done();
    finish_check("a");

    // 2x2 tiles with ragged edges, stall, stray tile_done and stray start
    push_tiles(5, 6, 3);
    kick(5, 6, 3);
    pulse_done();
    start = 1'b1;
    m = 4'd1;
    n = 4'd1;
    k = 4'd1;
    tick();
    start = 1'b0;
    repeat (5) begin
      chk("b_stall_valid", 64'(cmd_valid), 64'(1));
      chk("b_stall_cmd", 64'(seen()), 64'(exp_q[0]));
      tick();
    end
`ifdef TPU_SCHED_PREFETCH_EN
    accept("b0");
    chk("b_prefetch_valid", 64'(cmd_valid), 64'(1));
    accept("b1");
    repeat (3) begin
      chk("b_full_valid", 64'(cmd_valid), 64'(0));
      tick();
    end
    pulse_done();
    pulse_done();
    accept("b2");
    accept("b3");
    pulse_done();
    pulse_done();
`else
    for (int i = 0; i < 4; i++) begin
      accept($sformatf("b%0d", i));
      repeat (2) begin
        chk("b_single_valid", 64'(cmd_valid), 64'(0));
        tick();
      end
      pulse_done();
    end
`endif
    finish_check("b");

    // Zero dimension
    kick(0, 4, 4);
    chk("z_busy_t1", 64'(busy), 64'(1));
    chk("z_done_t1", 64'(done), 64'(0));
    chk("z_valid_t1", 64'(cmd_valid), 64'(0));
    tick();
    chk("z_done_t2", 64'(done), 64'(1));
    chk("z_valid_t2", 64'(cmd_valid), 64'(0));
    tick();
    chk("z_done_t3", 64'(done), 64'(0));
    chk("z_busy_t3", 64'(busy), 64'(0));

    // Reset after the second handshake, then a clean restart
    push_tiles(5, 6, 3);
    kick(5, 6, 3);
`ifdef TPU_SCHED_PREFETCH_EN
    accept("r0");
    accept("r1");
`else
    accept("r0");
    pulse_done();
    accept("r1");
`endif
    rst = 1'b1;
    #1;
    chk("r_busy", 64'(busy), 64'(0));
    chk("r_done", 64'(done), 64'(0));
    chk("r_valid", 64'(cmd_valid), 64'(0));
    chk("r_cmd", 64'(seen()), 64'(0));
    chk("r_idle", 64'(dut.state_q == ST_IDLE), 64'(1));
    tick();
    rst = 1'b0;
    exp_q.delete();
    pulse_done();
    repeat (3) begin
      chk("r_post_valid", 64'(cmd_valid), 64'(0));
      chk("r_post_busy", 64'(busy), 64'(0));
      chk("r_post_done", 64'(done), 64'(0));
      tick();
    end
    push_tiles(4, 4, 4);
    kick(4, 4, 4);
    accept("r_restart");
    pulse_done();
    finish_check("r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
